// File: rtl/layer_seq.sv
`default_nettype none
// ============================================================================
//  Module   : layer_seq
//  Purpose  : Per-layer sequencer for a streaming datapath. Holds up to NL
//             four-word layer descriptors and, on start, walks layers
//             0..nlayers-1. For each layer it loads the geometry, then runs a
//             weight-load, bias-load and run phase, each separated by a
//             one-cycle gap. Phases whose count is zero are skipped.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             cfg_we/addr/data      - descriptor write port ({layer,word})
//             start, nlayers, abort - sequence control
//             src_*/dst_*           - monitored stream handshakes
//             run, wwrite, bwrite   - registered datapath mode controls
//             ss..kw                - current layer geometry
//             layer, busy, done     - status
//  Revision : 1.0 - initial release
// ============================================================================
module layer_seq #(
  parameter int NL = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [31:0] cfg_data,
  input  logic        start,
  input  logic [2:0]  nlayers,
  input  logic        abort,
  input  logic        src_valid,
  input  logic        src_ready,
  input  logic        dst_valid,
  input  logic        dst_ready,
  input  logic        dst_last,
  output logic        run,
  output logic        wwrite,
  output logic        bwrite,
  output logic [11:0] ss,
  output logic [11:0] ds,
  output logic [3:0]  id,
  output logic [3:0]  od,
  output logic [9:0]  is,
  output logic [9:0]  os,
  output logic [4:0]  ih,
  output logic [4:0]  iw,
  output logic [4:0]  oh,
  output logic [4:0]  ow,
  output logic [7:0]  fs,
  output logic [2:0]  kh,
  output logic [2:0]  kw,
  output logic [1:0]  layer,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_WLD  = 3'd2,
    S_BLD  = 3'd3,
    S_RUN  = 3'd4,
    S_GAP  = 3'd5,
    S_FIN  = 3'd6
  } state_t;

  state_t      state;
  state_t      gap_next;   // where the current GAP cycle leads
  logic [2:0]  nl_r;       // nlayers captured at start
  logic [13:0] cnt;
  logic [13:0] wcnt_r;
  logic [4:0]  bcnt_r;
  logic [12:0] nsamp_r;

  // Descriptor storage: always four rows so the 2-bit layer index is always
  // in range; rows at or above NL are simply never written.
  logic [31:0] desc [0:3][0:3];

  always_ff @(posedge clk) begin
    if (cfg_we && !busy && (32'(cfg_addr[3:2]) < NL)) begin
      desc[cfg_addr[3:2]][cfg_addr[1:0]] <= cfg_data;
    end
  end

  logic [31:0] cur_w0, cur_w1, cur_w2, cur_w3;
  assign cur_w0 = desc[layer][0];
  assign cur_w1 = desc[layer][1];
  assign cur_w2 = desc[layer][2];
  assign cur_w3 = desc[layer][3];

  wire unused_bits = ^{cur_w1[1:0], cur_w2[7:0]};

  logic [13:0] ld_wcnt;
  logic [4:0]  ld_bcnt;
  logic [12:0] ld_nsamp;
  assign ld_wcnt  = cur_w3[31:18];
  assign ld_bcnt  = cur_w3[17:13];
  assign ld_nsamp = cur_w3[12:0];

  logic   start_ok;
  logic   src_beat, dst_beat;
  state_t end_of_layer, after_w, after_b;

  assign start_ok = (nlayers != 3'd0) && (32'(nlayers) <= NL);
  assign src_beat = src_valid && src_ready;
  assign dst_beat = dst_valid && dst_ready && dst_last;

  // Destinations after each phase, using the registered counts of the layer
  // already loaded (valid from the WLD/BLD/RUN states onwards).
  assign end_of_layer = (({1'b0, layer} + 3'd1) < nl_r) ? S_LOAD : S_FIN;
  assign after_b = (nsamp_r != 13'd0) ? S_RUN : end_of_layer;
  assign after_w = (bcnt_r != 5'd0) ? S_BLD : after_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      gap_next <= S_IDLE;
      nl_r     <= 3'd0;
      cnt      <= 14'd0;
      wcnt_r   <= 14'd0;
      bcnt_r   <= 5'd0;
      nsamp_r  <= 13'd0;
      run      <= 1'b0;
      wwrite   <= 1'b0;
      bwrite   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      layer    <= 2'd0;
      ss <= '0; ds <= '0; fs <= '0;
      id <= '0; is <= '0; ih <= '0; iw <= '0; kh <= '0; kw <= '0;
      od <= '0; os <= '0; oh <= '0; ow <= '0;
    end else if (abort && state != S_IDLE) begin
      // Abort drops everything but leaves geometry as last loaded.
      state  <= S_IDLE;
      cnt    <= 14'd0;
      run    <= 1'b0;
      wwrite <= 1'b0;
      bwrite <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && start_ok) begin
            state <= S_LOAD;
            layer <= 2'd0;
            nl_r  <= nlayers;
            busy  <= 1'b1;
          end
        end

        S_LOAD: begin
          ss <= cur_w0[31:20]; ds <= cur_w0[19:8]; fs <= cur_w0[7:0];
          id <= cur_w1[31:28]; is <= cur_w1[27:18]; ih <= cur_w1[17:13];
          iw <= cur_w1[12:8];  kh <= cur_w1[7:5];   kw <= cur_w1[4:2];
          od <= cur_w2[31:28]; os <= cur_w2[27:18]; oh <= cur_w2[17:13];
          ow <= cur_w2[12:8];
          wcnt_r  <= ld_wcnt;
          bcnt_r  <= ld_bcnt;
          nsamp_r <= ld_nsamp;
          cnt     <= 14'd0;
          // Registered counts are not valid yet, so decide from storage.
          if (ld_wcnt != 14'd0) begin
            state  <= S_WLD;
            wwrite <= 1'b1;
          end else if (ld_bcnt != 5'd0) begin
            state  <= S_BLD;
            bwrite <= 1'b1;
          end else if (ld_nsamp != 13'd0) begin
            state <= S_RUN;
            run   <= 1'b1;
          end else begin
            state    <= S_GAP;
            gap_next <= end_of_layer;
          end
        end

        S_WLD: begin
          if (src_beat) begin
            cnt <= cnt + 14'd1;
            if ((cnt + 14'd1) == wcnt_r) begin
              state    <= S_GAP;
              wwrite   <= 1'b0;
              gap_next <= after_w;
            end
          end
        end

        S_BLD: begin
          if (src_beat) begin
            cnt <= cnt + 14'd1;
            if ((cnt + 14'd1) == {9'd0, bcnt_r}) begin
              state    <= S_GAP;
              bwrite   <= 1'b0;
              gap_next <= after_b;
            end
          end
        end

        S_RUN: begin
          if (dst_beat) begin
            cnt <= cnt + 14'd1;
            if ((cnt + 14'd1) == {1'b0, nsamp_r}) begin
              state    <= S_GAP;
              run      <= 1'b0;
              gap_next <= end_of_layer;
            end
          end
        end

        S_GAP: begin
          cnt   <= 14'd0;
          state <= gap_next;
          case (gap_next)
            S_BLD:   bwrite <= 1'b1;
            S_RUN:   run    <= 1'b1;
            S_LOAD:  layer  <= layer + 2'd1;
            S_FIN:   done   <= 1'b1;
            default: ;
          endcase
        end

        S_FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_layer_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_layer_seq
//  Purpose  : Directed self-checking bench for layer_seq.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_layer_seq;

  logic        clk = 1'b0;
  logic        reset, cfg_we, start, abort;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic [2:0]  nlayers;
  logic        src_valid, src_ready, dst_valid, dst_ready, dst_last;
  logic        run, wwrite, bwrite, busy, done;
  logic [11:0] ss, ds;
  logic [3:0]  id, od;
  logic [9:0]  is, os;
  logic [4:0]  ih, iw, oh, ow;
  logic [7:0]  fs;
  logic [2:0]  kh, kw;
  logic [1:0]  layer;

  int n_total = 0;
  int n_pass  = 0;
  int n;

  always #5 clk = ~clk;

  layer_seq #(.NL(4)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .start(start), .nlayers(nlayers), .abort(abort),
    .src_valid(src_valid), .src_ready(src_ready), .dst_valid(dst_valid),
    .dst_ready(dst_ready), .dst_last(dst_last),
    .run(run), .wwrite(wwrite), .bwrite(bwrite),
    .ss(ss), .ds(ds), .id(id), .od(od), .is(is), .os(os),
    .ih(ih), .iw(iw), .oh(oh), .ow(ow), .fs(fs), .kh(kh), .kw(kw),
    .layer(layer), .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [1:0] l, input logic [1:0] w, input logic [31:0] d);
    cfg_we   = 1'b1;
    cfg_addr = {l, w};
    cfg_data = d;
    tick();
    cfg_we   = 1'b0;
  endtask

  function automatic logic [31:0] mk_w3(input logic [13:0] wc, input logic [4:0] bc,
                                        input logic [12:0] ns);
    return {wc, bc, ns};
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      0:       return wwrite;
      1:       return bwrite;
      default: return run;
    endcase
  endfunction

  // Number of consecutive samples the selected mode control stays high.
  task automatic run_len(input int sel, output int len);
    len = 0;
    while (sig(sel) && len < 64) begin
      len++;
      tick();
    end
  endtask

  task automatic pulse_start(input logic [2:0] nl);
    start   = 1'b1;
    nlayers = nl;
    tick();
    start   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; nlayers = 3'd1; abort = 1'b0;
    src_valid = 1'b1; src_ready = 1'b1;
    dst_valid = 1'b1; dst_ready = 1'b1; dst_last = 1'b1;
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_modes", 32'({run, wwrite, bwrite}), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ih", 32'(ih), 0);
    reset = 1'b0;
    tick();

    // ---- layer 0: wcnt=3 bcnt=2 nsamp=1; ih=28 ----
    wr(2'd0, 2'd0, {12'h123, 12'h456, 8'h78});
    wr(2'd0, 2'd1, {4'h9, 10'h155, 5'd28, 5'd17, 3'd3, 3'd5, 2'b00});
    wr(2'd0, 2'd2, {4'hA, 10'h2AA, 5'd14, 5'd7, 8'h00});
    wr(2'd0, 2'd3, mk_w3(14'd3, 5'd2, 13'd1));
    pulse_start(3'd1);
    chk("load_busy", 32'(busy), 1);
    chk("load_ww", 32'(wwrite), 0);
    tick();
    chk("t1_ss", 32'(ss), 32'h123);
    chk("t1_ds", 32'(ds), 32'h456);
    chk("t1_ih", 32'(ih), 28);
    chk("t1_kw", 32'(kw), 5);
    chk("t1_os", 32'(os), 32'h2AA);
    run_len(0, n);
    chk("t1_wlen", 32'(n), 3);
    chk("t1_gap1", 32'({run, wwrite, bwrite}), 0);
    tick();
    run_len(1, n);
    chk("t1_blen", 32'(n), 2);
    chk("t1_gap2", 32'({run, wwrite, bwrite}), 0);
    tick();
    run_len(2, n);
    chk("t1_rlen", 32'(n), 1);
    chk("t1_gap3_done", 32'(done), 0);
    tick();
    chk("t1_done", 32'(done), 1);
    tick();
    chk("t1_done_end", 32'({done, busy}), 0);
    chk("t1_ih_held", 32'(ih), 28);

    // ---- two layers: ih 28 then 12; layer1 has only 2 run samples ----
    wr(2'd0, 2'd3, mk_w3(14'd1, 5'd0, 13'd1));
    wr(2'd1, 2'd0, {12'h001, 12'h002, 8'h03});
    wr(2'd1, 2'd1, {4'h1, 10'h011, 5'd12, 5'd6, 3'd1, 3'd1, 2'b00});
    wr(2'd1, 2'd2, {4'h2, 10'h022, 5'd3, 5'd4, 8'h00});
    wr(2'd1, 2'd3, mk_w3(14'd0, 5'd0, 13'd2));
    pulse_start(3'd2);
    tick();
    chk("t2_layer0", 32'(layer), 0);
    chk("t2_ih0", 32'(ih), 28);
    run_len(0, n);
    chk("t2_wlen", 32'(n), 1);
    tick();
    run_len(2, n);
    chk("t2_rlen0", 32'(n), 1);
    tick();
    chk("t2_load1_layer", 32'(layer), 1);
    chk("t2_load1_ih", 32'(ih), 28);
    chk("t2_load1_done", 32'(done), 0);
    dst_last = 1'b0;
    tick();
    chk("t2_ih1", 32'(ih), 12);
    chk("t2_no_wb", 32'({wwrite, bwrite}), 0);
    chk("t2_run_on", 32'(run), 1);
    tick(); tick(); tick();
    chk("t2_run_nolast", 32'(run), 1);
    dst_last = 1'b1;
    tick();
    chk("t2_run_after1", 32'(run), 1);
    tick();
    chk("t2_run_after2", 32'(run), 0);
    tick();
    chk("t2_done", 32'(done), 1);
    tick();
    chk("t2_idle", 32'({done, busy}), 0);

    // ---- src_valid toggles without ready; then abort in RUN ----
    wr(2'd0, 2'd3, mk_w3(14'd2, 5'd0, 13'd3));
    src_ready = 1'b0;
    src_valid = 1'b0;
    pulse_start(3'd1);
    tick();
    for (int i = 0; i < 6; i++) begin
      src_valid = ~src_valid;
      tick();
    end
    chk("t3_ww_stall", 32'(wwrite), 1);
    src_valid = 1'b1;
    src_ready = 1'b1;
    tick();
    chk("t3_ww_beat1", 32'(wwrite), 1);
    tick();
    chk("t3_ww_beat2", 32'(wwrite), 0);
    src_ready = 1'b0;
    tick();
    dst_last = 1'b0;
    tick();
    chk("t3_run", 32'(run), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3_abort", 32'({run, busy}), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_no_done", 32'(done), 0);
    end
    wr(2'd0, 2'd3, mk_w3(14'd0, 5'd1, 13'd0));
    src_ready = 1'b1;
    pulse_start(3'd1);
    tick();
    chk("t3_bld_only", 32'({run, wwrite, bwrite}), 1);
    run_len(1, n);
    chk("t3_blen", 32'(n), 1);
    tick();
    chk("t3_done", 32'(done), 1);
    tick();

    // ---- cfg writes while busy ignored; reset mid-WLD ----
    wr(2'd0, 2'd3, mk_w3(14'd4, 5'd0, 13'd0));
    src_valid = 1'b0;
    pulse_start(3'd1);
    wr(2'd0, 2'd1, {4'h0, 10'h000, 5'd5, 5'd0, 3'd0, 3'd0, 2'b00});
    wr(2'd0, 2'd3, mk_w3(14'd1, 5'd0, 13'd0));
    chk("t4_wld", 32'(wwrite), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_rst_modes", 32'({run, wwrite, bwrite, busy, done}), 0);
    chk("t4_rst_geom", 32'({ss, ih, kw}), 0);
    chk("t4_rst_layer", 32'(layer), 0);
    src_valid = 1'b1;
    pulse_start(3'd1);
    tick();
    chk("t4_ih_kept", 32'(ih), 28);
    run_len(0, n);
    chk("t4_wlen_kept", 32'(n), 4);
    tick();
    chk("t4_done", 32'(done), 1);
    tick();

    // ---- illegal nlayers ignored; abort+start in IDLE takes start ----
    pulse_start(3'd0);
    chk("t5_nl0", 32'(busy), 0);
    pulse_start(3'd5);
    chk("t5_nl5", 32'(busy), 0);
    abort = 1'b1;
    pulse_start(3'd1);
    abort = 1'b0;
    chk("t5_abort_start", 32'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort_load", 32'({busy, done}), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/layer_seq.md
LAYER_SEQ -- requirements
Module: layer_seq

Interface
REQ-001 Parameter NL, default 4, meaning number of layer descriptor slots (1..4).
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cfg_we  in  1  descriptor write strobe.
REQ-005 cfg_addr  in  4  {layer[3:2], word[1:0]}.
REQ-006 cfg_data  in  32  descriptor word.
REQ-007 start  in  1  one-cycle pulse; begins sequence.
REQ-008 nlayers  in  3  layers to execute, 1..NL; sampled at start.
REQ-009 abort  in  1  terminate sequence.
REQ-010 src_valid, src_ready, dst_valid, dst_ready, dst_last  in  1 each  stream signals monitored, not driven.
REQ-011 run, wwrite, bwrite  out  1 each  datapath mode controls.
REQ-012 ss,ds 12; id,od 4; is,os 10; ih,iw,oh,ow 5; fs 8; kh,kw 3  out  current layer geometry.
REQ-013 layer  out  2  index of active layer.
REQ-014 busy  out  1  sequence in progress.
REQ-015 done  out  1  one-cycle completion pulse.

Function
REQ-016 Descriptor words: w0={ss[31:20],ds[19:8],fs[7:0]}; w1={id[31:28],is[27:18],ih[17:13],iw[12:8],kh[7:5],kw[4:2]}; w2={od[31:28],os[27:18],oh[17:13],ow[12:8]}; w3={wcnt[31:18],bcnt[17:13],nsamp[12:0]}.
REQ-017 cfg_we writes the word at cfg_addr when busy=0; ignored when busy=1; layer field >= NL ignored.
REQ-018 FSM states: IDLE, LOAD, WLD, BLD, RUN, GAP, FIN.
REQ-019 IDLE: start=1 -> LOAD with layer=0, busy=1; start with nlayers=0 or >NL ignored.
REQ-020 LOAD (1 cycle): register geometry outputs and wcnt/bcnt/nsamp of current layer; -> WLD if wcnt>0, else BLD if bcnt>0, else RUN if nsamp>0, else GAP.
REQ-021 WLD: wwrite=1; counter increments on src_valid&src_ready; on the beat making count==wcnt -> GAP; next phase BLD/RUN/GAP chosen by the same zero-skip rule.
REQ-022 BLD: bwrite=1; same counting on bcnt; completion -> GAP.
REQ-023 RUN: run=1; counter increments on dst_valid&dst_ready&dst_last; count==nsamp -> GAP.
REQ-024 GAP: exactly one cycle with run=wwrite=bwrite=0; then next phase, or, after RUN/skipped RUN, layer+1 -> LOAD if layer+1<nlayers, else FIN.
REQ-025 run, wwrite, bwrite registered; at most one high in any cycle; none high in LOAD, GAP, FIN, IDLE.
REQ-026 Geometry outputs change only in LOAD; held otherwise, including after FIN.
REQ-027 FIN (1 cycle): done=1, busy=0 next cycle, -> IDLE.
REQ-028 Counters 14 bits, cleared on every phase entry; no wrap within legal counts.
REQ-029 abort=1 in any non-IDLE state -> IDLE next cycle, mode controls low, busy=0, no done; abort in IDLE no effect.
REQ-030 start while busy ignored; abort and start same cycle in IDLE: start taken.
REQ-031 Beat on the completing cycle of a phase counts once; beats during GAP/LOAD not counted.

Reset
REQ-032 reset=1 -> IDLE; run=wwrite=bwrite=busy=done=0, layer=0, geometry outputs 0, counters 0.
REQ-033 Descriptor storage not cleared by reset.
REQ-034 reset mid-sequence takes precedence over all inputs, same effect as REQ-032.

Verification
REQ-035 Layer0 w3 wcnt=3,bcnt=2,nsamp=1, nlayers=1, start -> wwrite for 3 beats, 1 gap, bwrite for 2 beats, gap, run until 1 dst_last, gap, done pulse.
REQ-036 Two layers with distinct ih (28, 12): ih=28 during layer0 phases, ih=12 after second LOAD, layer 0->1, single done.
REQ-037 wcnt=0,bcnt=0,nsamp=2 -> no wwrite/bwrite, run high until second dst_last handshake.
REQ-038 src_valid toggling with src_ready low during WLD -> count unchanged, wwrite stays high.
REQ-039 abort during RUN -> run low and busy low next cycle, done never asserted; cfg_we then accepted.
REQ-040 cfg_we while busy changes no descriptor; reset mid-WLD -> all outputs 0, descriptor contents preserved on next start.
